// File: rtl/jk_bank_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver_if
// Purpose  : Target handshake and JK bank signals of jk_bank_driver.
//            The slave modport is the driver's view; the master modport is
//            the view of whatever feeds targets and models the bank.
// Revision : 1.0  initial release
// ============================================================================
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] mismatch;
    logic [15:0]      xfer_cnt;

    modport slave (
        input  tgt_valid, tgt_data, q_in,
        output tgt_ready, j_out, k_out, done, err, mismatch, xfer_cnt
    );

    modport master (
        output tgt_valid, tgt_data, q_in,
        input  tgt_ready, j_out, k_out, done, err, mismatch, xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Purpose  : Write side of a bank of JK flip-flops. Takes a target vector,
//            drives one cycle of J/K excitation, waits SETTLE cycles, reads Q
//            back and reports done, or err once MAX_RETRY re-drives fail.
// Revision : 1.0  initial release
// ============================================================================
module jk_bank_driver #(
    parameter int WIDTH      = 4,
    parameter int SETTLE     = 1,
    parameter int MAX_RETRY  = 2,
    parameter int USE_TOGGLE = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    jk_bank_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam bit         c_HAS_SETTLE  = (SETTLE > 0);
    localparam logic [3:0] c_SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [2:0] c_MAX_RETRY   = 3'(MAX_RETRY);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
    logic [WIDTH-1:0] r_j, w_j_nxt;
    logic [WIDTH-1:0] r_k, w_k_nxt;
    logic [WIDTH-1:0] r_mismatch, w_mismatch_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic [15:0]      r_xfer_cnt, w_xfer_cnt_nxt;
    logic [2:0]       r_retry, w_retry_nxt;
    logic [3:0]       r_settle, w_settle_nxt;

    // Excitation target: the incoming vector while idle, the latched one on retry.
    logic [WIDTH-1:0] w_exc_t;
    logic [WIDTH-1:0] w_exc_j;
    logic [WIDTH-1:0] w_exc_k;

    assign w_exc_t = (r_state == ST_IDLE) ? bus.tgt_data : r_tgt;

    generate
        if (USE_TOGGLE != 0) begin : g_toggle
            // Every differing bit toggles; equal bits hold.
            assign w_exc_j = bus.q_in ^ w_exc_t;
            assign w_exc_k = bus.q_in ^ w_exc_t;
        end else begin : g_set_reset
            // 0->1 sets, 1->0 resets; equal bits hold.
            assign w_exc_j = ~bus.q_in &  w_exc_t;
            assign w_exc_k =  bus.q_in & ~w_exc_t;
        end
    endgenerate

    // Next-state and next-output logic; J/K default to zero outside DRIVE entry.
    always_comb begin
        w_state_nxt    = r_state;
        w_tgt_nxt      = r_tgt;
        w_j_nxt        = '0;
        w_k_nxt        = '0;
        w_mismatch_nxt = r_mismatch;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_xfer_cnt_nxt = r_xfer_cnt;
        w_retry_nxt    = r_retry;
        w_settle_nxt   = r_settle;

        case (r_state)
            ST_IDLE: begin
                if (bus.tgt_valid) begin
                    w_tgt_nxt   = bus.tgt_data;
                    w_j_nxt     = w_exc_j;
                    w_k_nxt     = w_exc_k;
                    w_retry_nxt = '0;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_settle_nxt = '0;
                w_state_nxt  = c_HAS_SETTLE ? ST_WAIT : ST_CHECK;
            end
            ST_WAIT: begin
                if (r_settle == c_SETTLE_LAST) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_settle_nxt = r_settle + 4'd1;
                end
            end
            ST_CHECK: begin
                if (bus.q_in == r_tgt) begin
                    w_done_nxt     = 1'b1;
                    w_xfer_cnt_nxt = r_xfer_cnt + 16'd1;
                    w_state_nxt    = ST_IDLE;
                end else if (r_retry < c_MAX_RETRY) begin
                    w_retry_nxt = r_retry + 3'd1;
                    w_j_nxt     = w_exc_j;
                    w_k_nxt     = w_exc_k;
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_err_nxt      = 1'b1;
                    w_mismatch_nxt = bus.q_in ^ r_tgt;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and silences J/K.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tgt      <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_mismatch <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_xfer_cnt <= '0;
            r_retry    <= '0;
            r_settle   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tgt      <= w_tgt_nxt;
            r_j        <= w_j_nxt;
            r_k        <= w_k_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_xfer_cnt <= w_xfer_cnt_nxt;
            r_retry    <= w_retry_nxt;
            r_settle   <= w_settle_nxt;
        end
    end

    assign bus.tgt_ready = (r_state == ST_IDLE);
    assign bus.j_out     = r_j;
    assign bus.k_out     = r_k;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mismatch  = r_mismatch;
    assign bus.xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_driver
// Purpose  : Self-checking bench for jk_bank_driver. Two instances (set/reset
//            and toggle encoding) each drive a behavioural JK bank; results
//            are predicted into a scoreboard and popped when done/err fire.
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_bank_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    jk_bank_driver_if #(.WIDTH(4)) ifa ();
    jk_bank_driver_if #(.WIDTH(4)) ift ();

    jk_bank_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .USE_TOGGLE(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    jk_bank_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .USE_TOGGLE(1)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (ift.slave)
    );

    // Behavioural JK banks; stuck_a pins bit0 of bank A at 0.
    logic [3:0] qa = 4'b0000;
    logic [3:0] qt = 4'b0000;
    logic       load_a = 1'b0;
    logic       load_t = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic       stuck_a = 1'b0;

    // JK characteristic equation Q+ = J~Q | ~KQ, with optional direct load.
    always @(posedge clk) begin
        if (load_a) qa <= load_val;
        else        qa <= ((ifa.j_out & ~qa) | (~ifa.k_out & qa)) & ~{3'b000, stuck_a};
        if (load_t) qt <= load_val;
        else        qt <= (ift.j_out & ~qt) | (~ift.k_out & qt);
    end

    assign ifa.q_in = qa;
    assign ift.q_in = qt;

    typedef struct {
        bit         is_err;
        logic [3:0] mm;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    // Reference excitation from the per-bit truth table; returns {J, K}.
    function automatic logic [7:0] exc_model(input bit tog, input logic [3:0] q, input logic [3:0] t);
        logic [3:0] j;
        logic [3:0] k;
        for (int i = 0; i < 4; i++) begin
            case ({q[i], t[i]})
                2'b01:   begin j[i] = 1'b1; k[i] = tog; end
                2'b10:   begin j[i] = tog;  k[i] = 1'b1; end
                default: begin j[i] = 1'b0; k[i] = 1'b0; end
            endcase
        end
        return {j, k};
    endfunction

    task automatic push_exp(input bit is_err, input logic [3:0] mm);
        if (!is_err) exp_cnt = exp_cnt + 16'd1;
        sb_q.push_back('{is_err, mm, exp_cnt});
    endtask

    // Scoreboard consumer for instance A: every done/err pops one expectation.
    always @(negedge clk) begin
        if (!rst && (ifa.done === 1'b1 || ifa.err === 1'b1)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: done=%b err=%b, required no pulse", ifa.done, ifa.err);
            end else begin
                mon_e = sb_q.pop_front();
                if (ifa.err !== mon_e.is_err || ifa.done !== ~mon_e.is_err) begin
                    bad++;
                    $display("FAIL sb_kind: done=%b err=%b, required err=%b", ifa.done, ifa.err, mon_e.is_err);
                end
                total++;
                if (ifa.xfer_cnt !== mon_e.cnt) begin
                    bad++;
                    $display("FAIL sb_xfer_cnt: got %0d required %0d", ifa.xfer_cnt, mon_e.cnt);
                end
                if (mon_e.is_err) begin
                    total++;
                    if (ifa.mismatch !== mon_e.mm) begin
                        bad++;
                        $display("FAIL sb_mismatch: got %b required %b", ifa.mismatch, mon_e.mm);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_bank(input bit sel_t, input logic [3:0] v);
        load_val = v;
        if (sel_t) load_t = 1'b1;
        else       load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        load_t = 1'b0;
    endtask

    // Offers a target; returns on the negedge of the DRIVE cycle.
    task automatic send(input bit sel_t, input logic [3:0] d);
        bit ok;
        ok = 1'b0;
        if (sel_t) begin ift.tgt_valid = 1'b1; ift.tgt_data = d; end
        else       begin ifa.tgt_valid = 1'b1; ifa.tgt_data = d; end
        for (int i = 0; i < 20; i++) begin
            if ((sel_t ? ift.tgt_ready : ifa.tgt_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (sel_t) ift.tgt_valid = 1'b0;
        else       ifa.tgt_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout: tgt_ready=0, required 1 within 20 cycles");
        end
    endtask

    task automatic wait_pulse(input bit sel_t, input int max, output int n);
        n = 0;
        while (n < max && !(sel_t ? (ift.done === 1'b1 || ift.err === 1'b1)
                                  : (ifa.done === 1'b1 || ifa.err === 1'b1))) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        ifa.tgt_valid = 1'b0; ifa.tgt_data = 4'b0000;
        ift.tgt_valid = 1'b0; ift.tgt_data = 4'b0000;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        sb_q.delete();
        exp_cnt = 16'd0;
        cyc(1);
        total++; if (ifa.tgt_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b required 1", ifa.tgt_ready); end
        total++; if (ifa.j_out !== 4'b0 || ifa.k_out !== 4'b0) begin bad++; $display("FAIL rst_jk: got j=%b k=%b required 0000", ifa.j_out, ifa.k_out); end
        total++; if (ifa.done !== 1'b0 || ifa.err !== 1'b0) begin bad++; $display("FAIL rst_pulse: got done=%b err=%b required 0", ifa.done, ifa.err); end
        total++; if (ifa.xfer_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d required 0", ifa.xfer_cnt); end
        total++; if (ifa.mismatch !== 4'b0) begin bad++; $display("FAIL rst_mismatch: got %b required 0000", ifa.mismatch); end
        total++; if (ift.tgt_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_t: got %b required 1", ift.tgt_ready); end
    endtask

    task automatic test_set_reset;
        logic [7:0] e;
        int n;
        load_bank(1'b0, 4'b0000);
        e = exc_model(1'b0, 4'b0000, 4'b1010);
        push_exp(1'b0, 4'b0000);
        send(1'b0, 4'b1010);
        total++; if ({ifa.j_out, ifa.k_out} !== e) begin bad++; $display("FAIL sr_jk: got j=%b k=%b required %b", ifa.j_out, ifa.k_out, e); end
        total++; if (ifa.tgt_ready !== 1'b0) begin bad++; $display("FAIL sr_busy: got ready=%b required 0", ifa.tgt_ready); end
        wait_pulse(1'b0, 10, n);
        total++; if (n !== 3 || ifa.done !== 1'b1) begin bad++; $display("FAIL sr_latency: got %0d cycles done=%b required 3 done=1", n, ifa.done); end
        cyc(1);
        total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL sr_pulse: got done=%b required 0", ifa.done); end
        total++; if (qa !== 4'b1010) begin bad++; $display("FAIL sr_bank: got %b required 1010", qa); end
    endtask

    task automatic test_toggle;
        logic [7:0] e;
        int n;
        load_bank(1'b1, 4'b1100);
        e = exc_model(1'b1, 4'b1100, 4'b0110);
        send(1'b1, 4'b0110);
        total++; if ({ift.j_out, ift.k_out} !== e) begin bad++; $display("FAIL tog_jk: got j=%b k=%b required %b", ift.j_out, ift.k_out, e); end
        wait_pulse(1'b1, 10, n);
        total++; if (n !== 3 || ift.done !== 1'b1) begin bad++; $display("FAIL tog_latency: got %0d cycles done=%b required 3 done=1", n, ift.done); end
        total++; if (ift.xfer_cnt !== 16'd1) begin bad++; $display("FAIL tog_cnt: got %0d required 1", ift.xfer_cnt); end
        total++; if (qt !== 4'b0110) begin bad++; $display("FAIL tog_bank: got %b required 0110", qt); end
        cyc(1);
    endtask

    task automatic test_retry_err;
        int drives;
        bit seen_err;
        bit seen_done;
        load_bank(1'b0, 4'b0000);
        stuck_a = 1'b1;
        drives = 0; seen_err = 1'b0; seen_done = 1'b0;
        push_exp(1'b1, 4'b0001);
        send(1'b0, 4'b0001);
        for (int i = 0; i < 30; i++) begin
            if (ifa.j_out !== 4'b0000) begin
                drives++;
                total++;
                if (ifa.j_out !== 4'b0001 || ifa.k_out !== 4'b0000) begin
                    bad++;
                    $display("FAIL retry_jk: got j=%b k=%b required j=0001 k=0000", ifa.j_out, ifa.k_out);
                end
            end
            if (ifa.done === 1'b1) seen_done = 1'b1;
            if (ifa.err === 1'b1) begin seen_err = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (drives !== 3) begin bad++; $display("FAIL retry_drives: got %0d required 3", drives); end
        total++; if (!seen_err) begin bad++; $display("FAIL retry_err: got no err required err"); end
        total++; if (seen_done) begin bad++; $display("FAIL retry_done: got done=1 required 0"); end
        stuck_a = 1'b0;
        cyc(1);
    endtask

    task automatic test_busy_ignore;
        logic [7:0] e;
        int n;
        push_exp(1'b0, 4'b0000);
        send(1'b0, 4'b0011);
        ifa.tgt_valid = 1'b1;
        ifa.tgt_data  = 4'b0101;
        push_exp(1'b0, 4'b0000);
        total++; if (ifa.tgt_ready !== 1'b0 || ifa.j_out !== 4'b0011) begin bad++; $display("FAIL busy_drive: got ready=%b j=%b required 0 0011", ifa.tgt_ready, ifa.j_out); end
        cyc(1);
        total++; if (ifa.tgt_ready !== 1'b0 || ifa.j_out !== 4'b0000) begin bad++; $display("FAIL busy_wait: got ready=%b j=%b required 0 0000", ifa.tgt_ready, ifa.j_out); end
        cyc(2);
        total++; if (ifa.done !== 1'b1 || ifa.tgt_ready !== 1'b1) begin bad++; $display("FAIL busy_done: got done=%b ready=%b required 1 1", ifa.done, ifa.tgt_ready); end
        cyc(1);
        ifa.tgt_valid = 1'b0;
        e = exc_model(1'b0, 4'b0011, 4'b0101);
        total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got done=%b required 0", ifa.done); end
        total++; if ({ifa.j_out, ifa.k_out} !== e) begin bad++; $display("FAIL b2b_jk: got j=%b k=%b required %b", ifa.j_out, ifa.k_out, e); end
        wait_pulse(1'b0, 10, n);
        total++; if (n !== 3) begin bad++; $display("FAIL b2b_latency: got %0d required 3", n); end
        total++; if (qa !== 4'b0101) begin bad++; $display("FAIL b2b_bank: got %b required 0101", qa); end
        total++; if (ifa.mismatch !== 4'b0001) begin bad++; $display("FAIL mismatch_hold: got %b required 0001", ifa.mismatch); end
        cyc(1);
    endtask

    task automatic test_equal_target;
        int n;
        push_exp(1'b0, 4'b0000);
        send(1'b0, 4'b0101);
        total++; if (ifa.j_out !== 4'b0 || ifa.k_out !== 4'b0 || ifa.tgt_ready !== 1'b0) begin bad++; $display("FAIL eq_drive: got j=%b k=%b ready=%b required 0000 0000 0", ifa.j_out, ifa.k_out, ifa.tgt_ready); end
        wait_pulse(1'b0, 10, n);
        total++; if (n !== 3 || ifa.done !== 1'b1) begin bad++; $display("FAIL eq_latency: got %0d cycles done=%b required 3 done=1", n, ifa.done); end
        cyc(1);
    endtask

    task automatic test_reset_midop;
        logic [7:0] e;
        int pulses;
        e = exc_model(1'b0, 4'b0101, 4'b1010);
        send(1'b0, 4'b1010);
        total++; if ({ifa.j_out, ifa.k_out} !== e) begin bad++; $display("FAIL mid_drive: got j=%b k=%b required %b", ifa.j_out, ifa.k_out, e); end
        rst = 1'b1;
        cyc(1);
        total++; if (ifa.j_out !== 4'b0 || ifa.k_out !== 4'b0) begin bad++; $display("FAIL mid_jk: got j=%b k=%b required 0000", ifa.j_out, ifa.k_out); end
        total++; if (ifa.tgt_ready !== 1'b1) begin bad++; $display("FAIL mid_idle: got ready=%b required 1", ifa.tgt_ready); end
        rst = 1'b0;
        sb_q.delete();
        exp_cnt = 16'd0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifa.done === 1'b1 || ifa.err === 1'b1) pulses++;
            @(negedge clk);
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_pulse: got %0d pulses required 0", pulses); end
        total++; if (ifa.xfer_cnt !== 16'd0 || ifa.mismatch !== 4'b0) begin bad++; $display("FAIL mid_cnt: got cnt=%0d mm=%b required 0 0000", ifa.xfer_cnt, ifa.mismatch); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_set_reset();
        test_toggle();
        test_retry_err();
        test_busy_ignore();
        test_equal_target();
        test_reset_midop();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
